decryptiontop: RTL and testbench

DECRYPTIONTOP -- requirements
Module: decryptiontop

---
 rtl/decryptiontop.sv | 211 +++++++++++++++++++++
 tb/tb_decryptiontop.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decryptiontop.sv
// AES-256 block decryptor: expands the key one round key per cycle,
// then runs one inverse round per cycle; fixed 28-cycle latency.
// Ports: clk, rst (sync, active-high), start, ciphertext[127:0],
//   key_i[255:0] in; plaintext[127:0], busy, done out.
module decryptiontop (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [255:0] key_i,
    output logic [127:0] plaintext,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE, KEYEXP, INIT, ROUND, FINAL
    } fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,
        8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,
        8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,
        8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,
        8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,
        8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,
        8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,
        8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,
        8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,
        8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,
        8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,
        8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,
        8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,
        8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,
        8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,
        8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,
        8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,
        8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,
        8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,
        8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,
        8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,
        8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,
        8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,
        8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,
        8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,
        8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,
        8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,
        8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,
        8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,
        8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,
        8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,
        8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,
        8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiplier built from the x8/x4/x2/x1 doubling chain.
    function automatic logic [7:0] gm(input logic [7:0] b,
                                      input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb)
                             ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
            o[119-32*c -: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he)
                             ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
            o[111-32*c -: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9)
                             ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
            o[103-32*c -: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd)
                             ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
        end
        return o;
    endfunction

    fsm_t         fsm;
    logic [127:0] rk [16];
    logic [127:0] ct_q;
    logic [127:0] st;
    logic [3:0]   idx;
    logic [3:0]   round;

    logic [31:0]  kw3;
    logic [31:0]  sw_in;
    logic [31:0]  t;
    logic [127:0] kpp;
    logic [127:0] next_rk;
    logic [127:0] inv_sr_sb;
    logic [127:0] round_out;

    always_comb begin
        kw3   = rk[idx - 4'd1][31:0];
        kpp   = rk[idx - 4'd2];
        // Even keys rotate before substitution and add Rcon.
        sw_in = idx[0] ? kw3 : {kw3[23:0], kw3[31:24]};
        t     = {SBOX[sw_in[31:24]], SBOX[sw_in[23:16]],
                 SBOX[sw_in[15:8]],  SBOX[sw_in[7:0]]};
        if (!idx[0])
            t = t ^ {8'h01 << (idx[3:1] - 3'd1), 24'h0};
        next_rk[127:96] = kpp[127:96] ^ t;
        next_rk[95:64]  = kpp[95:64] ^ next_rk[127:96];
        next_rk[63:32]  = kpp[63:32] ^ next_rk[95:64];
        next_rk[31:0]   = kpp[31:0]  ^ next_rk[63:32];

        // Row r of column c comes from column (c - r) mod 4.
        inv_sr_sb = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                inv_sr_sb[127-8*(4*c+r) -: 8] =
                    INV_SBOX[st[127-8*(4*((c-r)&3)+r) -: 8]];
        round_out = inv_mix(inv_sr_sb ^ rk[round]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            idx       <= '0;
            round     <= '0;
            plaintext <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: if (start) begin
                    ct_q  <= ciphertext;
                    rk[0] <= key_i[255:128];
                    rk[1] <= key_i[127:0];
                    idx   <= 4'd2;
                    busy  <= 1'b1;
                    fsm   <= KEYEXP;
                end
                KEYEXP: begin
                    rk[idx] <= next_rk;
                    idx     <= idx + 4'd1;
                    if (idx == 4'd14)
                        fsm <= INIT;
                end
                INIT: begin
                    st    <= ct_q ^ rk[14];
                    round <= 4'd13;
                    fsm   <= ROUND;
                end
                ROUND: begin
                    st    <= round_out;
                    round <= round - 4'd1;
                    if (round == 4'd1)
                        fsm <= FINAL;
                end
                FINAL: begin
                    plaintext <= inv_sr_sb ^ rk[0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    fsm       <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decryptiontop.sv
// Directed bench for decryptiontop: FIPS vectors, latency,
// start/reset corner cases and round trips from a reference encryptor.
module tb_decryptiontop;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] ciphertext;
    logic [255:0] key_i;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [256];

    localparam logic [255:0] K_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_Z  = 128'hdc95c078a2408989ad48a21492842087;

    always #5 clk = ~clk;

    decryptiontop dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ciphertext (ciphertext),
        .key_i      (key_i),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // Forward S-box derived from the GF inverse plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                             input logic [255:0] key);
        logic [31:0]  w [60];
        logic [31:0]  tw;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   n [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            tw = w[i-1];
            if (i % 8 == 0) begin
                tw = subw({tw[23:0], tw[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tw = subw(tw);
            end
            w[i] = w[i-8] ^ tw;
        end
        for (int i = 0; i < 16; i++)
            s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    n[4*c+q] = sb[s[4*((c+q)%4)+q]];
            for (int c = 0; c < 4; c++) begin
                a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
                if (r < 14) begin
                    s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // One operation from a single start pulse; optional input scramble
    // after the start edge and optional spurious start at cycle spur_k.
    task automatic run_op(input string tag, input logic [127:0] ct,
                          input logic [255:0] k, input logic [127:0] exp,
                          input bit scramble, input int spur_k,
                          input int span);
        int   busy_n  = 0;
        int   done_at = 0;
        int   done_n  = 0;
        logic busy_at_done = 1'b1;
        @(negedge clk);
        start = 1'b1; ciphertext = ct; key_i = k;
        for (int n = 1; n <= span; n++) begin
            @(negedge clk);
            start = (n == spur_k);
            if (scramble && n == 1) begin
                ciphertext = ~ct; key_i = ~k;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = n;
                    busy_at_done = busy;
                end
            end
        end
        start = 1'b0;
        check({tag, ":latency"}, 128'(done_at), 128'(29));
        check({tag, ":busy_cycles"}, 128'(busy_n), 128'(28));
        check({tag, ":done_pulses"}, 128'(done_n), 128'(1));
        check({tag, ":busy_at_done"}, 128'(busy_at_done), 128'(0));
        check({tag, ":plaintext"}, plaintext, exp);
    endtask

    initial begin
        int          dn;
        int          prev;
        logic [127:0] p;
        logic [255:0] k;
        build_sbox();
        rst = 1'b1; start = 1'b0; ciphertext = '0; key_i = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_pt", plaintext, 128'h0);
        rst = 1'b0;

        run_op("c3", CT_C3, K_C3, PT_C3, 1'b0, 0, 40);
        run_op("zero_key", CT_Z, 256'h0, 128'h0, 1'b1, 0, 40);
        run_op("spur_start", CT_C3, K_C3, PT_C3, 1'b0, 10, 70);

        // Held start: back-to-back operations every 29 cycles.
        dn = 0; prev = 0;
        @(negedge clk);
        start = 1'b1; ciphertext = CT_C3; key_i = K_C3;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                check($sformatf("b2b_pt%0d", dn), plaintext, PT_C3);
                check($sformatf("b2b_gap%0d", dn), 128'(n - prev), 128'(29));
                prev = n;
                if (dn == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_count", 128'(dn), 128'(3));

        // Reset during the fifth ROUND cycle.
        @(negedge clk);
        start = 1'b1; ciphertext = CT_C3; key_i = K_C3;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_pt", plaintext, 128'h0);
        dn = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("rst_no_done", 128'(dn), 128'(0));
        run_op("after_rst", CT_C3, K_C3, PT_C3, 1'b0, 0, 40);

        // Round trips through the reference encryptor.
        for (int i = 0; i < 100; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
            run_op($sformatf("rand%0d", i), aes_enc(p, k), k, p,
                   1'b0, 0, 35);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
